floppy_head_emulator: RTL

FLOPPY_HEAD_EMULATOR -- requirements
Module: floppy_head_emulator

---
 rtl/floppy_head_emulator.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/floppy_head_emulator.sv
// Purpose: emulates a floppy drive head positioner driven by STEP/DIR lines, with rate and limit checking.
// Latency: head_track/step_count/step_accepted update on the 3rd clk edge after step_pulse is first sampled high.
// Backpressure: none; steps arriving too soon are dropped and flagged, steps past the end stops are absorbed.
module floppy_head_emulator #(
    parameter int MAX_TRACK       = 83,
    parameter int MIN_STEP_CYCLES = 2000,
    parameter int SETTLE_CYCLES   = 15000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        step_pulse,
    input  logic        direction,
    input  logic        clear_err,
    output logic [7:0]  head_track,
    output logic        track0,
    output logic        settled,
    output logic        step_accepted,
    output logic        limit_hit,
    output logic        rate_err,
    output logic [15:0] step_count
);

    localparam int IW = (MIN_STEP_CYCLES < 1) ? 1 : $clog2(MIN_STEP_CYCLES + 1);
    localparam int SW = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);

    localparam logic [IW-1:0] IVL_MAX    = IW'(MIN_STEP_CYCLES);
    localparam logic [SW-1:0] SETTLE_LD  = SW'(SETTLE_CYCLES);
    localparam logic [7:0]    TRK_MAX    = 8'(MAX_TRACK);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_SETTLE = 1'b1;

    // Synchronizers, edge history and arming
    logic [1:0]    step_sync_q, step_sync_d;
    logic [1:0]    dir_sync_q, dir_sync_d;
    logic          step_prev_q, step_prev_d;
    logic [1:0]    fill_q, fill_d;
    logic          armed_q, armed_d;

    // Head state, timers and flags
    logic [IW-1:0] ivl_q, ivl_d;
    logic [0:0]    state_q, state_d;
    logic [SW-1:0] settle_q, settle_d;
    logic [7:0]    track_q, track_d;
    logic [15:0]   count_q, count_d;
    logic          acc_q, acc_d;
    logic          lim_q, lim_d;
    logic          rate_q, rate_d;

    logic          step_evt;
    logic          step_dir;
    logic          rate_ok;
    logic          accept;
    logic          rate_viol;
    logic          at_limit;

    // Step event qualification: edge of the synchronized line, only once armed
    always_comb begin
        step_sync_d = {step_sync_q[0], step_pulse};
        dir_sync_d  = {dir_sync_q[0], direction};
        step_prev_d = step_sync_q[1];
        // fill_q[1] marks that step_sync_q[1] now reflects a post-reset sample;
        // arming requires seeing the line low so a level held through reset is ignored
        fill_d      = {fill_q[0], 1'b1};
        armed_d     = armed_q | (fill_q[1] & ~step_sync_q[1]);
        step_evt    = armed_q & step_sync_q[1] & ~step_prev_q;
        step_dir    = dir_sync_q[1];
        rate_ok     = (ivl_q == IVL_MAX);
        accept      = step_evt & rate_ok;
        rate_viol   = step_evt & ~rate_ok;
        at_limit    = step_dir ? (track_q >= TRK_MAX) : (track_q == 8'd0);
    end

    // Head position, step counter, interval timer and sticky error flags
    always_comb begin
        track_d = track_q;
        count_d = count_q;
        acc_d   = accept;
        ivl_d   = rate_ok ? ivl_q : ivl_q + IW'(1);
        // a new error in the same cycle as clear_err wins
        lim_d   = lim_q & ~clear_err;
        rate_d  = (rate_q & ~clear_err) | rate_viol;
        if (accept) begin
            count_d = count_q + 16'd1;
            ivl_d   = '0;
            if (at_limit) begin
                lim_d = 1'b1;
            end else if (step_dir) begin
                track_d = track_q + 8'd1;
            end else begin
                track_d = track_q - 8'd1;
            end
        end
    end

    // Settle FSM: every accepted step (re)starts the settle interval
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d  = ST_SETTLE;
                    settle_d = SETTLE_LD;
                end
            end
            default: begin
                if (accept) begin
                    settle_d = SETTLE_LD;
                end else if (settle_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    settle_d = settle_q - SW'(1);
                end
            end
        endcase
    end

    // State registers; reset aborts any settle or synchronization in flight
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            step_sync_q <= '0;
            dir_sync_q  <= '0;
            step_prev_q <= 1'b0;
            fill_q      <= '0;
            armed_q     <= 1'b0;
            ivl_q       <= IVL_MAX;
            state_q     <= ST_IDLE;
            settle_q    <= '0;
            track_q     <= '0;
            count_q     <= '0;
            acc_q       <= 1'b0;
            lim_q       <= 1'b0;
            rate_q      <= 1'b0;
        end else begin
            step_sync_q <= step_sync_d;
            dir_sync_q  <= dir_sync_d;
            step_prev_q <= step_prev_d;
            fill_q      <= fill_d;
            armed_q     <= armed_d;
            ivl_q       <= ivl_d;
            state_q     <= state_d;
            settle_q    <= settle_d;
            track_q     <= track_d;
            count_q     <= count_d;
            acc_q       <= acc_d;
            lim_q       <= lim_d;
            rate_q      <= rate_d;
        end
    end

    assign head_track    = track_q;
    assign track0        = (track_q == 8'd0);
    assign settled       = (state_q == ST_IDLE);
    assign step_accepted = acc_q;
    assign limit_hit     = lim_q;
    assign rate_err      = rate_q;
    assign step_count    = count_q;

endmodule
